// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2, K=3 convolutional encoder (g0 = 7 octal, g1 = 5 octal).
// Takes a framed serial bit stream over valid/ready and emits one registered
// 2-bit code symbol per bit: sym_out[1] = g0 output, sym_out[0] = g1 output.
// State sr[1] = u(n-1), sr[0] = u(n-2), numbered as the Viterbi decoder expects.
// Optional build macro CONV_ENC_TAIL_EN: when defined, every frame is closed
// with two zero tail bits so the trellis ends in state 00; when undefined the
// state is forced to 00 as the last data bit is accepted.
module conv_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [1:0]       sym_out,
    output logic             sym_valid,
    output logic             sym_last,
    input  logic             sym_ready,
    output logic [CNT_W-1:0] frame_len
);

    typedef enum logic [1:0] {
        ST_DATA  = 2'd0,
        ST_TAIL0 = 2'd1,
        ST_TAIL1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Generator taps: g0 = u ^ u(n-1) ^ u(n-2), g1 = u ^ u(n-2).
    function automatic logic [1:0] encode_sym(input logic u, input logic [1:0] sr);
        return {u ^ sr[1] ^ sr[0], u ^ sr[0]};
    endfunction

    // Saturating increment so very long frames report the maximum count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [1:0]       sr_r;
    logic [1:0]       sr_next_s;
    logic [CNT_W-1:0] bit_cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             load_s;
    logic             accept_s;
    logic             step_s;
    logic             u_s;
    logic             last_s;
    logic [1:0]       sym_s;

    // The output register can take a new symbol when empty or being drained.
    assign load_s    = !sym_valid || sym_ready;
    assign accept_s  = in_valid && in_ready;
    assign cnt_inc_s = sat_inc(bit_cnt_r);
    assign sym_s     = encode_sym(u_s, sr_r);

    // Input handshake: data is only taken in DATA with room in the output register.
    always_comb begin
        in_ready = 1'b0;
        case (state_r)
            ST_DATA: begin
                in_ready = load_s;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Next-state, next shift register and the symbol to load this cycle.
    always_comb begin
        step_s       = 1'b0;
        u_s          = 1'b0;
        last_s       = 1'b0;
        sr_next_s    = sr_r;
        state_next_s = state_r;
        case (state_r)
            ST_DATA: begin
                if (accept_s) begin
                    step_s    = 1'b1;
                    u_s       = in_bit;
                    sr_next_s = {in_bit, sr_r[1]};
                    if (in_last) begin
`ifdef CONV_ENC_TAIL_EN
                        state_next_s = ST_TAIL0;
`else
                        last_s       = 1'b1;
                        sr_next_s    = 2'b00;
                        state_next_s = ST_DATA;
`endif
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    step_s = 1'b0;
                end
            end
`ifdef CONV_ENC_TAIL_EN
            ST_TAIL0: begin
                if (load_s) begin
                    step_s       = 1'b1;
                    u_s          = 1'b0;
                    sr_next_s    = {1'b0, sr_r[1]};
                    state_next_s = ST_TAIL1;
                end else begin
                    step_s = 1'b0;
                end
            end
            ST_TAIL1: begin
                if (load_s) begin
                    step_s       = 1'b1;
                    u_s          = 1'b0;
                    last_s       = 1'b1;
                    sr_next_s    = {1'b0, sr_r[1]};
                    state_next_s = ST_DATA;
                end else begin
                    step_s = 1'b0;
                end
            end
`endif
            default: begin
                sr_next_s    = 2'b00;
                state_next_s = ST_DATA;
            end
        endcase
    end

    // FSM, shift register and registered symbol output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_DATA;
            sr_r      <= 2'b00;
            sym_out   <= 2'b00;
            sym_valid <= 1'b0;
            sym_last  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            sr_r    <= sr_next_s;
            if (load_s) begin
                sym_valid <= step_s;
                sym_last  <= step_s && last_s;
                if (step_s) begin
                    sym_out <= sym_s;
                end else begin
                    sym_out <= sym_out;
                end
            end else begin
                sym_valid <= sym_valid;
                sym_last  <= sym_last;
                sym_out   <= sym_out;
            end
        end
    end

    // Frame bit counter; the final count is published when in_last is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_r <= {CNT_W{1'b0}};
            frame_len <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            if (in_last) begin
                frame_len <= cnt_inc_s;
                bit_cnt_r <= {CNT_W{1'b0}};
            end else begin
                bit_cnt_r <= cnt_inc_s;
            end
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

endmodule

// File: tb/tb_conv_encoder.sv
// Directed testbench for conv_encoder. Expected symbol sequences are worked out
// by hand from g0 = 7, g1 = 5 and depend on whether CONV_ENC_TAIL_EN is defined.
// Captured symbols are packed as {sym_last, sym_out}.
module tb_conv_encoder;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_bit;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [1:0]       sym_out;
    logic             sym_valid;
    logic             sym_last;
    logic             sym_ready;
    logic [CNT_W-1:0] frame_len;

    int n_total = 0;
    int n_bad   = 0;

    logic [2:0] cap_q[$];
    logic [2:0] exp_q[$];

    conv_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .sym_out   (sym_out),
        .sym_valid (sym_valid),
        .sym_last  (sym_last),
        .sym_ready (sym_ready),
        .frame_len (frame_len)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Record every symbol that will be handed over at the next rising edge.
    always @(negedge clk) begin
        if (!reset && sym_valid && sym_ready) begin
            cap_q.push_back({sym_last, sym_out});
        end
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sync_edge();
        @(posedge clk);
        #1;
    endtask

    // Present one bit and hold it until accepted; returns 1 time unit after the accepting edge.
    task automatic send(input logic b, input logic l);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_bit   = b;
        in_last  = l;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            check("send_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_bit   = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for n captured symbols, then compare against exp_q.
    task automatic compare_seq(input string tag, input int n);
        for (int i = 0; i < 50 && cap_q.size() < n; i++) begin
            @(posedge clk);
        end
        #1;
        check({tag, "_count"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            check($sformatf("%s_sym%0d", tag, i), {29'd0, cap_q[i]}, {29'd0, exp_q[i]});
        end
        cap_q.delete();
    endtask

    initial begin
        reset     = 1'b1;
        sym_ready = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_sym_valid", sym_valid, 1'b0);
        check("rst_sym_last", sym_last, 1'b0);
        check("rst_sym_out", sym_out, 2'b00);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_frame_len", frame_len, 16'd0);
        sync_edge();
        cap_q.delete();

        // Reference frame 1,0,1,1
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        idle();
        check("ref_frame_len", frame_len, 16'd4);
`ifdef CONV_ENC_TAIL_EN
        @(negedge clk);
        check("ref_tail_ready0", in_ready, 1'b0);
        @(negedge clk);
        check("ref_tail_ready1", in_ready, 1'b0);
        @(negedge clk);
        check("ref_tail_ready2", in_ready, 1'b1);
        exp_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
`else
        @(negedge clk);
        check("ref_ready_after", in_ready, 1'b1);
        exp_q = '{3'b011, 3'b010, 3'b000, 3'b101};
`endif
        sync_edge();
        compare_seq("ref", exp_q.size());

        // Following frame 1,0 must start from state 00
        send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        idle();
        check("f2_frame_len", frame_len, 16'd2);
`ifdef CONV_ENC_TAIL_EN
        exp_q = '{3'b011, 3'b010, 3'b011, 3'b100};
`else
        exp_q = '{3'b011, 3'b110};
`endif
        compare_seq("f2", exp_q.size());

        // Backpressure after the first symbol of the reference frame
        send(1'b1, 1'b0);
        sym_ready = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("bp_sym_out%0d", i), sym_out, 2'b11);
            check($sformatf("bp_valid%0d", i), sym_valid, 1'b1);
            check($sformatf("bp_ready%0d", i), in_ready, 1'b0);
        end
        sym_ready = 1'b1;
        sync_edge();
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        idle();
`ifdef CONV_ENC_TAIL_EN
        exp_q = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
`else
        exp_q = '{3'b011, 3'b010, 3'b000, 3'b101};
`endif
        compare_seq("bp", exp_q.size());

        // Reset mid-tail (or mid-frame without tail)
`ifdef CONV_ENC_TAIL_EN
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
`else
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
`endif
        idle();
        reset = 1'b1;
        sync_edge();
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_sym_valid", sym_valid, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_frame_len", frame_len, 16'd0);
        sync_edge();
        cap_q.delete();
`ifdef CONV_ENC_TAIL_EN
        send(1'b1, 1'b1);
        idle();
        exp_q = '{3'b011, 3'b010, 3'b111};
`else
        send(1'b1, 1'b0);
        send(1'b0, 1'b1);
        idle();
        exp_q = '{3'b011, 3'b110};
`endif
        compare_seq("after_rst", exp_q.size());

        // Back-to-back frames of length 1 and 3
        send(1'b1, 1'b1);
        check("b2b_len1", frame_len, 16'd1);
        send(1'b1, 1'b0);
        send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        idle();
        check("b2b_len3", frame_len, 16'd3);
`ifdef CONV_ENC_TAIL_EN
        exp_q = '{3'b011, 3'b010, 3'b111, 3'b011, 3'b010, 3'b000, 3'b010, 3'b111};
`else
        exp_q = '{3'b111, 3'b011, 3'b010, 3'b100};
`endif
        compare_seq("b2b", exp_q.size());

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
